// File: rtl/sq_err_window_reader.sv
// sq_err_window_reader
//   Windowed reader/controller for the err_sq_gen squared-error accumulator.
//   It drives err_sq_gen's hold input to cut fixed windows of 2^WIN_LOG2
//   clk_en periods. At each window end it captures the full accumulator and
//   scales it to a 1s17 mean squared error. It also tracks min/max/count over
//   windows and offers every result on a valid/ready port.
//
// Ports
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-high reset
//   clk_en       in   1      symbol-rate enable, shared with err_sq_gen
//   enable       in   1      measurement run; low forces IDLE
//   clr_stats    in   1      pulse; clears min/max/count/overrun
//   acc_in       in   ACC_W  signed accumulator from err_sq_gen acc_out_full
//   hold         out  1      to err_sq_gen hold; clears its accumulator
//   res_valid    out  1      result available
//   res_ready    in   1      consumer accepts result
//   res_mean     out  18     window mean, saturated
//   res_min      out  18     minimum res_mean since reset/clr_stats
//   res_max      out  18     maximum res_mean since reset/clr_stats
//   res_win_cnt  out  16     windows reported since reset/clr_stats, saturating
//   res_sat      out  1      mean of current result was saturated
//   overrun      out  1      sticky; a result was overwritten before acceptance

module sq_err_window_reader #(
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned ACC_W    = 18 + WIN_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             enable,
    input  logic             clr_stats,
    input  logic [ACC_W-1:0] acc_in,
    output logic             hold,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [17:0]      res_mean,
    output logic [17:0]      res_min,
    output logic [17:0]      res_max,
    output logic [15:0]      res_win_cnt,
    output logic             res_sat,
    output logic             overrun
);

    localparam int unsigned MEAN_W = 18;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SLC_W  = ACC_W - WIN_LOG2;

    localparam logic [WIN_LOG2-1:0] SYM_LAST = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] SYM_PRE  = {{(WIN_LOG2-1){1'b1}}, 1'b0};
    localparam logic [MEAN_W-1:0]   SAT_MEAN = 18'h1FFFF;
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIN_LOG2-1:0] r_sym_cnt;
    logic                r_hold;
    logic                r_res_valid;
    logic [MEAN_W-1:0]   r_res_mean;
    logic [MEAN_W-1:0]   r_res_min;
    logic [MEAN_W-1:0]   r_res_max;
    logic [CNT_W-1:0]    r_res_win_cnt;
    logic                r_res_sat;
    logic                r_overrun;

    logic [SLC_W-1:0]    w_mean_slice;
    logic [MEAN_W-1:0]   w_mean;
    logic                w_mean_sat;
    logic                w_capture;
    logic                w_run_cap;
    logic                w_xfer;
    logic                w_stats_empty;

    // Scaled mean; a set MSB means the accumulator wrapped negative.
    assign w_mean_slice = acc_in[ACC_W-1:WIN_LOG2];
    assign w_mean_sat   = acc_in[ACC_W-1];
    assign w_mean       = w_mean_sat ? SAT_MEAN : MEAN_W'(w_mean_slice);

    // Capture edge: hold was presented across this clk_en and the window is full.
    // enable low abandons a pending capture.
    assign w_capture = (r_state != ST_IDLE) && enable && clk_en && r_hold &&
                       (r_sym_cnt == SYM_LAST);
    assign w_run_cap = w_capture && (r_state == ST_RUN);
    assign w_xfer    = r_res_valid && res_ready;

    // A saturating counter never returns to zero, so zero means "no window yet".
    assign w_stats_empty = (r_res_win_cnt == '0);

    // FSM, window counter, result register and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sym_cnt     <= '0;
            r_hold        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_mean    <= '0;
            r_res_min     <= '0;
            r_res_max     <= '0;
            r_res_win_cnt <= '0;
            r_res_sat     <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Window sequencing
            case (r_state)
                ST_IDLE: begin
                    r_sym_cnt <= '0;
                    r_hold    <= 1'b0;
                    if (enable) begin
                        r_state <= ST_WARMUP;
                    end
                end
                ST_WARMUP, ST_RUN: begin
                    if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_sym_cnt <= '0;
                        r_hold    <= 1'b0;
                    end else if (w_capture) begin
                        r_sym_cnt <= '0;
                        r_hold    <= 1'b0;
                        // The window that started at enable is partial: drop it.
                        if (r_state == ST_WARMUP) begin
                            r_state <= ST_RUN;
                        end
                    end else if (clk_en) begin
                        r_sym_cnt <= r_sym_cnt + WIN_LOG2'(1);
                        // Registered hold leads the capture clk_en by one period.
                        r_hold    <= (r_sym_cnt == SYM_PRE);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_sym_cnt <= '0;
                    r_hold    <= 1'b0;
                end
            endcase

            // Result register; a capture on a transfer edge keeps valid high.
            if (w_run_cap) begin
                r_res_valid <= 1'b1;
                r_res_mean  <= w_mean;
                r_res_sat   <= w_mean_sat;
            end else if (w_xfer) begin
                r_res_valid <= 1'b0;
            end

            // Statistics; a clear coinciding with a capture restarts from that window.
            if (clr_stats) begin
                if (w_run_cap) begin
                    r_res_min     <= w_mean;
                    r_res_max     <= w_mean;
                    r_res_win_cnt <= CNT_W'(1);
                end else begin
                    r_res_min     <= '0;
                    r_res_max     <= '0;
                    r_res_win_cnt <= '0;
                end
            end else if (w_run_cap) begin
                if (w_stats_empty || (w_mean < r_res_min)) begin
                    r_res_min <= w_mean;
                end
                if (w_stats_empty || (w_mean > r_res_max)) begin
                    r_res_max <= w_mean;
                end
                if (r_res_win_cnt != CNT_MAX) begin
                    r_res_win_cnt <= r_res_win_cnt + CNT_W'(1);
                end
            end

            // Overwrite of an unaccepted result is a fresh event and beats a clear.
            if (w_run_cap && r_res_valid && !res_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_stats) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign hold        = r_hold;
    assign res_valid   = r_res_valid;
    assign res_mean    = r_res_mean;
    assign res_min     = r_res_min;
    assign res_max     = r_res_max;
    assign res_win_cnt = r_res_win_cnt;
    assign res_sat     = r_res_sat;
    assign overrun     = r_overrun;

endmodule
